// File: rtl/mig_serial_eval.sv
// Serial evaluator for 4-input majority-inverter networks: one shared MAJ3
// unit walks every gate for each of the 16 input patterns to build a truth table.
module mig_serial_eval #(
  parameter int MAX_GATES = 8,
  parameter int NODE_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [2:0]              cfg_addr,
  input  logic [3*(NODE_W+1)-1:0] cfg_data,
  input  logic [3:0]              num_gates,
  input  logic [NODE_W-1:0]       out_sel,
  input  logic                    out_inv,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [15:0]             tt
);

  localparam int AW = (MAX_GATES > 1) ? $clog2(MAX_GATES) : 1;
  localparam int NN = 1 << NODE_W;
  localparam int DW = 3 * (NODE_W + 1);

  typedef enum logic [1:0] {IDLE, EVAL, FIN} state_t;

  state_t                state, state_next;
  logic [DW-1:0]         desc [MAX_GATES];
  logic [MAX_GATES-1:0]  res;
  logic [3:0]            p, g, gates;
  logic [NODE_W-1:0]     osel;
  logic                  oinv;

  logic [NN-1:0]         nodes;
  logic [DW-1:0]         cur;
  logic [NODE_W-1:0]     sel;
  logic [2:0]            opv;
  logic                  bad, maj, start_bad, gate_cycle;
  logic [AW-1:0]         g_idx;

  assign g_idx = g[AW-1:0];

  // Node vector indexed directly by a node select: const0, x0..x3, gate results.
  always_comb begin
    nodes                  = '0;
    nodes[4:1]             = p;
    nodes[5 +: MAX_GATES]  = res;
  end

  always_comb begin
    cur = desc[g_idx];
    sel = '0;
    opv = '0;
    bad = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      sel    = cur[k*(NODE_W+1) +: NODE_W];
      opv[k] = nodes[sel] ^ cur[k*(NODE_W+1) + NODE_W];
      if (int'(sel) >= 5 + int'(g)) bad = 1'b1;
    end
    maj = (opv[0] & opv[1]) | (opv[0] & opv[2]) | (opv[1] & opv[2]);
  end

  assign start_bad  = (int'(num_gates) > MAX_GATES) ||
                      (int'(out_sel) > 4 + int'(num_gates));
  assign gate_cycle = (g != gates);

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = start_bad ? FIN : EVAL;
      EVAL: begin
        busy = 1'b1;
        if (gate_cycle) begin
          if (bad) state_next = FIN;
        end else if (p == 4'd15) begin
          state_next = FIN;
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_GATES; i++) desc[i] <= '0;
      res   <= '0;
      p     <= '0;
      g     <= '0;
      gates <= '0;
      osel  <= '0;
      oinv  <= 1'b0;
      tt    <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_we) desc[cfg_addr[AW-1:0]] <= cfg_data;
          if (start) begin
            gates <= num_gates;
            osel  <= out_sel;
            oinv  <= out_inv;
            tt    <= '0;
            err   <= start_bad;
            p     <= '0;
            g     <= '0;
          end
        end
        EVAL: begin
          if (gate_cycle) begin
            if (bad) begin
              err <= 1'b1;
              tt  <= '0;
            end else begin
              res[g_idx] <= maj;
              g          <= g + 4'd1;
            end
          end else begin
            tt[p] <= nodes[osel] ^ oinv;
            g     <= '0;
            if (p != 4'd15) p <= p + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
